// File: rtl/dds_burst_sequencer.sv
// DDS burst sequencer: per shot, issues N bursts of exact carrier-cycle counts separated by idle gaps.
// Latency: start at edge t -> LOAD at t+1 -> dds_en high from t+2; every output is registered.
// Backpressure: none; start is ignored while busy, abort forces IDLE from any state.
module dds_burst_sequencer #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8,
  parameter int GAP_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ACC_W-1:0] cfg_fword,
  input  logic [11:0]      cfg_pword,
  input  logic [CNT_W-1:0] cfg_cycles,
  input  logic [CNT_W-1:0] cfg_bursts,
  input  logic [GAP_W-1:0] cfg_gap,
  output logic             dds_en,
  output logic [ACC_W-1:0] Fword,
  output logic [11:0]      Pword,
  output logic [CNT_W-1:0] burst_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, LOAD, BURST, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] sh_fword_q, sh_fword_d;
  logic [11:0]      sh_pword_q, sh_pword_d;
  logic [CNT_W-1:0] sh_cycles_q, sh_cycles_d;
  logic [CNT_W-1:0] sh_bursts_q, sh_bursts_d;
  logic [GAP_W-1:0] sh_gap_q, sh_gap_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             dds_en_q, dds_en_d;
  logic [ACC_W-1:0] fword_q, fword_d;
  logic [11:0]      pword_q, pword_d;
  logic [CNT_W-1:0] burst_idx_q, burst_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Carry-out of the widened sum marks one completed carrier cycle.
  logic [ACC_W:0]   acc_sum;
  logic             carry;
  logic             gap_last;

  assign acc_sum  = {1'b0, acc_q} + {1'b0, sh_fword_q};
  assign carry    = acc_sum[ACC_W];
  // A programmed gap of 0 still costs one idle clock.
  assign gap_last = (sh_gap_q == '0) ? (gap_cnt_q == '0)
                                     : (gap_cnt_q == sh_gap_q - GAP_W'(1));

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    sh_fword_d  = sh_fword_q;
    sh_pword_d  = sh_pword_q;
    sh_cycles_d = sh_cycles_q;
    sh_bursts_d = sh_bursts_q;
    sh_gap_d    = sh_gap_q;
    acc_d       = acc_q;
    cyc_cnt_d   = cyc_cnt_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    fword_d     = fword_q;
    pword_d     = pword_q;
    burst_idx_d = burst_idx_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          sh_fword_d  = cfg_fword;
          sh_pword_d  = cfg_pword;
          sh_cycles_d = cfg_cycles;
          sh_bursts_d = cfg_bursts;
          sh_gap_d    = cfg_gap;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        fword_d     = sh_fword_q;
        pword_d     = sh_pword_q;
        acc_d       = '0;
        cyc_cnt_d   = '0;
        burst_cnt_d = '0;
        burst_idx_d = '0;
        if (sh_cycles_q == '0 || sh_bursts_q == '0 || sh_fword_q == '0)
          state_d = DONE;
        else
          state_d = BURST;
      end
      BURST: begin
        acc_d = acc_sum[ACC_W-1:0];
        if (carry) begin
          // Exit tests use equality before increment so counters never wrap.
          if (cyc_cnt_q == sh_cycles_q - CNT_W'(1)) begin
            if (burst_cnt_q == sh_bursts_q - CNT_W'(1)) begin
              state_d = DONE;
            end else begin
              state_d     = GAP;
              gap_cnt_d   = '0;
              burst_cnt_d = burst_cnt_q + CNT_W'(1);
              burst_idx_d = burst_idx_q + CNT_W'(1);
            end
          end else begin
            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_last) begin
          // Restart from zero phase so every burst begins at Pword.
          state_d   = BURST;
          acc_d     = '0;
          cyc_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) state_d = IDLE;

    dds_en_d = (state_d == BURST);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  // State, shadow, counter and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      sh_fword_q  <= '0;
      sh_pword_q  <= '0;
      sh_cycles_q <= '0;
      sh_bursts_q <= '0;
      sh_gap_q    <= '0;
      acc_q       <= '0;
      cyc_cnt_q   <= '0;
      burst_cnt_q <= '0;
      gap_cnt_q   <= '0;
      dds_en_q    <= 1'b0;
      fword_q     <= '0;
      pword_q     <= '0;
      burst_idx_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_fword_q  <= sh_fword_d;
      sh_pword_q  <= sh_pword_d;
      sh_cycles_q <= sh_cycles_d;
      sh_bursts_q <= sh_bursts_d;
      sh_gap_q    <= sh_gap_d;
      acc_q       <= acc_d;
      cyc_cnt_q   <= cyc_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      dds_en_q    <= dds_en_d;
      fword_q     <= fword_d;
      pword_q     <= pword_d;
      burst_idx_q <= burst_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dds_en    = dds_en_q;
  assign Fword     = fword_q;
  assign Pword     = pword_q;
  assign burst_idx = burst_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dds_burst_sequencer.sv
// Directed bench for dds_burst_sequencer: records per-cycle traces of each shot
// and compares burst windows, gaps, indices and done/busy timing against
// hand-computed values.
module tb_dds_burst_sequencer;

  logic        Clk;
  logic        Rst_n;
  logic        start;
  logic        abort;
  logic [31:0] cfg_fword;
  logic [11:0] cfg_pword;
  logic [7:0]  cfg_cycles;
  logic [7:0]  cfg_bursts;
  logic [15:0] cfg_gap;
  logic        dds_en;
  logic [31:0] Fword;
  logic [11:0] Pword;
  logic [7:0]  burst_idx;
  logic        busy;
  logic        done;

  int tests_run;
  int tests_failed;

  logic       tr_en   [0:511];
  logic       tr_busy [0:511];
  logic       tr_done [0:511];
  logic [7:0] tr_idx  [0:511];
  logic [11:0] tr_pw  [0:511];
  logic [31:0] tr_fw  [0:511];

  int nwin, ndone, dpos, lastbusy, nbusy;
  int ws [0:7];
  int wl [0:7];
  int wi [0:7];

  dds_burst_sequencer #(.ACC_W(32), .CNT_W(8), .GAP_W(16)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .start      (start),
    .abort      (abort),
    .cfg_fword  (cfg_fword),
    .cfg_pword  (cfg_pword),
    .cfg_cycles (cfg_cycles),
    .cfg_bursts (cfg_bursts),
    .cfg_gap    (cfg_gap),
    .dds_en     (dds_en),
    .Fword      (Fword),
    .Pword      (Pword),
    .burst_idx  (burst_idx),
    .busy       (busy),
    .done       (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Configure and raise start; the next negedge is sample 0 (LOAD visible).
  task automatic shot(input logic [31:0] fw, input logic [11:0] pw, input logic [7:0] cyc,
                      input logic [7:0] bur, input logic [15:0] gap);
    cfg_fword  = fw;
    cfg_pword  = pw;
    cfg_cycles = cyc;
    cfg_bursts = bur;
    cfg_gap    = gap;
    start      = 1'b1;
    @(negedge Clk);
  endtask

  // Record n samples; start/abort are pulsed right after samples st_at/ab_at.
  task automatic capture(input int n, input int st_at, input int ab_at);
    for (int k = 0; k < n; k++) begin
      tr_en[k]   = dds_en;
      tr_busy[k] = busy;
      tr_done[k] = done;
      tr_idx[k]  = burst_idx;
      tr_pw[k]   = Pword;
      tr_fw[k]   = Fword;
      start      = (k == st_at);
      abort      = (k == ab_at);
      @(negedge Clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic analyze(input int n);
    nwin = 0; ndone = 0; dpos = -1; lastbusy = -1; nbusy = 0;
    for (int k = 0; k < n; k++) begin
      if (tr_en[k] && (k == 0 || !tr_en[k-1]) && nwin < 8) begin
        ws[nwin] = k;
        wl[nwin] = 0;
        wi[nwin] = int'(tr_idx[k]);
        nwin++;
      end
      if (tr_en[k] && nwin > 0) wl[nwin-1]++;
      if (tr_done[k]) begin
        ndone++;
        if (dpos < 0) dpos = k;
      end
      if (tr_busy[k]) begin
        nbusy++;
        lastbusy = k;
      end
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    Rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_fword = '0; cfg_pword = '0; cfg_cycles = '0; cfg_bursts = '0; cfg_gap = '0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;

    // Reset state held while idle.
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      chk("idle_outs", {dds_en, busy, done, Fword, Pword}, 64'd0);
    end

    // Single burst: 4 cycles at 2^28 -> 64 clocks; late cfg change and start in DONE ignored.
    shot(32'h1000_0000, 12'h100, 8'd4, 8'd1, 16'd10);
    cfg_pword = 12'h3FF; cfg_cycles = 8'd1;
    capture(70, 65, -1);
    analyze(70);
    chk("s1_nwin", nwin, 1);
    chk("s1_start", ws[0], 1);
    chk("s1_len", wl[0], 64);
    chk("s1_pword", tr_pw[1], 12'h100);
    chk("s1_fword", tr_fw[1], 32'h1000_0000);
    chk("s1_ndone", ndone, 1);
    chk("s1_dpos", dpos, 65);
    chk("s1_lastbusy", lastbusy, 65);
    chk("s1_nbusy", nbusy, 66);

    // Three bursts, gap 10; a start during the first burst is ignored.
    shot(32'h1000_0000, 12'h0, 8'd4, 8'd3, 16'd10);
    capture(240, 30, -1);
    analyze(240);
    chk("s3_nwin", nwin, 3);
    chk("s3_ws0", ws[0], 1);
    chk("s3_ws1", ws[1], 75);
    chk("s3_ws2", ws[2], 149);
    for (int i = 0; i < 3; i++) begin
      chk("s3_len", wl[i], 64);
      chk("s3_idx", wi[i], i);
    end
    chk("s3_ndone", ndone, 1);
    chk("s3_dpos", dpos, 213);
    chk("s3_lastbusy", lastbusy, 213);

    // Non-power-of-two word: 3 cycles at 0x3000_0000 -> 16 clocks; gap 0 -> 1 idle clock.
    shot(32'h3000_0000, 12'h0, 8'd3, 8'd2, 16'd0);
    capture(50, -1, -1);
    analyze(50);
    chk("s4_nwin", nwin, 2);
    chk("s4_len0", wl[0], 16);
    chk("s4_len1", wl[1], 16);
    chk("s4_ws1", ws[1], 18);
    chk("s4_dpos", dpos, 34);

    // Degenerate configs: no burst, done 2 cycles after start, busy for 2 cycles.
    for (int c = 0; c < 3; c++) begin
      case (c)
        0:       shot(32'h1000_0000, 12'h0, 8'd0, 8'd2, 16'd3);
        1:       shot(32'h1000_0000, 12'h0, 8'd2, 8'd0, 16'd3);
        default: shot(32'h0, 12'h0, 8'd2, 8'd2, 16'd3);
      endcase
      capture(6, -1, -1);
      analyze(6);
      chk("dg_nwin", nwin, 0);
      chk("dg_dpos", dpos, 1);
      chk("dg_ndone", ndone, 1);
      chk("dg_nbusy", nbusy, 2);
    end

    // Abort in the 30th BURST clock of the first burst.
    shot(32'h1000_0000, 12'h0, 8'd4, 8'd3, 16'd10);
    capture(60, -1, 30);
    analyze(60);
    chk("ab_nwin", nwin, 1);
    chk("ab_len", wl[0], 30);
    chk("ab_ndone", ndone, 0);
    chk("ab_lastbusy", lastbusy, 30);

    // Abort during the second burst, then a fresh shot restarts at index 0.
    shot(32'h1000_0000, 12'h0, 8'd4, 8'd3, 16'd10);
    capture(100, -1, 90);
    analyze(100);
    chk("ab2_nwin", nwin, 2);
    chk("ab2_idx1", wi[1], 1);
    chk("ab2_len1", wl[1], 16);
    chk("ab2_ndone", ndone, 0);
    shot(32'h1000_0000, 12'h0, 8'd4, 8'd1, 16'd10);
    capture(70, -1, -1);
    analyze(70);
    chk("rs_idx0", tr_idx[1], 0);
    chk("rs_len", wl[0], 64);
    chk("rs_dpos", dpos, 65);

    // start and abort together in IDLE: stay idle.
    start = 1'b1; abort = 1'b1;
    @(negedge Clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    repeat (3) @(negedge Clk);
    chk("sa_en", dds_en, 0);

    // Asynchronous reset mid-burst drops everything without a clock edge.
    shot(32'h1000_0000, 12'h55, 8'd4, 8'd2, 16'd10);
    capture(20, -1, -1);
    chk("ar_pre_en", dds_en, 1);
    #2 Rst_n = 1'b0;
    #1;
    chk("ar_outs", {dds_en, busy, done, Fword, Pword, burst_idx}, 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("ar_idle", {dds_en, busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
